// File: rtl/bounded_counter_bank.sv
// bounded_counter_bank: bank of independent bounded up/down counters with clear, range-checked load and sticky overflow
module bounded_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 3,
  parameter int MAX_VAL = 3,
  parameter int WRAP = 0,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    load_valid,
  input  logic [CW-1:0]           load_ch,
  input  logic [WIDTH-1:0]        load_val,
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic [NUM_CH-1:0]       at_max,
  output logic [NUM_CH-1:0]       at_zero,
  output logic [NUM_CH-1:0]       ovf,
  input  logic [NUM_CH-1:0]       ovf_clr,
  output logic                    load_err
);
  localparam logic [WIDTH:0] MX = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
    $error("MAX_VAL must lie in 1..2**WIDTH-1");
  end
  logic [NUM_CH-1:0][WIDTH-1:0] cnt, nxt;
  logic [NUM_CH-1:0] evt;
  logic [WIDTH:0] v, up, dn, lv;
  logic hit, err;
  assign out = cnt;
  // one extra bit keeps bound tests free of modulo-2^WIDTH aliasing
  always_comb begin
    nxt = cnt;
    evt = '0;
    at_max = '0;
    at_zero = '0;
    v = '0;
    up = '0;
    dn = '0;
    hit = 1'b0;
    lv = {1'b0, load_val} > MX ? MX : {1'b0, load_val};
    err = load_valid && ({1'b0, load_val} > MX || int'(load_ch) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      v = {1'b0, cnt[i]};
      up = v == MX ? (WRAP != 0 ? '0 : MX) : v + ONE;
      dn = v == '0 ? (WRAP != 0 ? MX : '0) : v - ONE;
      hit = load_valid && load_ch == CW'(i);
      nxt[i] = clr[i] ? '0 : hit ? lv[WIDTH-1:0] : en[i] ? (dir[i] ? up[WIDTH-1:0] : dn[WIDTH-1:0]) : cnt[i];
      evt[i] = en[i] && !clr[i] && !hit && (dir[i] ? v == MX : v == '0);
      at_max[i] = v == MX;
      at_zero[i] = v == '0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      ovf <= '0;
      load_err <= 1'b0;
    end else begin
      cnt <= nxt;
      ovf <= evt | (ovf & ~ovf_clr);
      load_err <= err;
    end
  end
endmodule
